// File: rtl/resize_pkg.sv
// rtl/resize_pkg.sv - shared geometry, counter width and state type for the binary resize path
//
// Purpose: constants shared by binarize_feeder and the downstream 2x2 resize stage.
// Ports:   none (package).
package resize_pkg;

  localparam int IMG_W       = 64;
  localparam int IMG_H       = 64;
  localparam int WIN_OFS     = 2*IMG_W + 2;
  localparam int FLUSH_LEN   = IMG_W + 1;
  localparam int FRAME_BEATS = IMG_W*IMG_H;
  localparam int CNT_W       = 13;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } feed_state_t;

  // True when beat n completes an even-row, even-column 2x2 window. The
  // row-parity bit of (n - offset) is the bit whose weight is img_w, which
  // holds because img_w is a power of two.
  function automatic logic win_hit(input logic [CNT_W-1:0] n, input int img_w);
    logic [CNT_W-1:0] ofs;
    logic [CNT_W-1:0] m;
    ofs = CNT_W'(2*img_w + 2);
    m   = n - ofs;
    return (n >= ofs) && !m[0] && ((m & CNT_W'(img_w)) == '0);
  endfunction

endpackage

// File: rtl/binarize_feeder.sv
// rtl/binarize_feeder.sv - thresholds a grayscale pixel stream into the 1-bit resize front end
//
// Purpose: accepts IMG_W x IMG_H pixels (valid/ready), emits one thresholded bit
//          per beat, appends IMG_W+1 zero flush beats and raises cal_valid for
//          every even-aligned 2x2 window.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   pix_data/valid/sof      input pixel stream, sof marks pixel (0,0)
//   pix_ready               registered ready
//   thr                     threshold, latched on the sof beat
//   bin_data/bin_valid      serial 1-bit output beat
//   cal_valid               window-aligned calculate strobe (one cycle after its beat)
//   frame_done/frame_err    complete-frame pulse / truncated-frame pulse
module binarize_feeder
  import resize_pkg::*;
#(
  parameter int IMG_W = resize_pkg::IMG_W,
  parameter int IMG_H = resize_pkg::IMG_H,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_valid,
  input  logic             pix_sof,
  output logic             pix_ready,
  input  logic [PIX_W-1:0] thr,
  output logic             bin_data,
  output logic             bin_valid,
  output logic             cal_valid,
  output logic             frame_done,
  output logic             frame_err
);

  localparam int FRAME_LAST = IMG_W*IMG_H - 1;
  localparam int BEAT_LAST  = IMG_W*IMG_H + IMG_W;

  feed_state_t      state;
  logic [CNT_W-1:0] n;       // index of the next beat to emit
  logic [CNT_W-1:0] n_out;   // index of the beat currently on bin_data
  logic [PIX_W-1:0] thr_q;
  logic             accept;

  assign accept = pix_valid && pix_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      n          <= '0;
      n_out      <= '0;
      thr_q      <= '0;
      pix_ready  <= 1'b0;
      bin_data   <= 1'b0;
      bin_valid  <= 1'b0;
      cal_valid  <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      bin_valid  <= 1'b0;
      frame_err  <= 1'b0;
      // The strobe trails the beat it belongs to by one cycle, so it is
      // derived from the registered output beat rather than the input.
      cal_valid  <= bin_valid && win_hit(n_out, IMG_W);
      frame_done <= bin_valid && (n_out == CNT_W'(BEAT_LAST));

      case (state)
        ST_IDLE, ST_STREAM: begin
          pix_ready <= 1'b1;
          if (accept) begin
            if (pix_sof) begin
              // A sof always restarts the frame; the old frame is dropped
              // without a flush and flagged if it was still in progress.
              thr_q     <= thr;
              bin_data  <= (pix_data >= thr);
              bin_valid <= 1'b1;
              n_out     <= '0;
              n         <= CNT_W'(1);
              state     <= ST_STREAM;
              frame_err <= (state == ST_STREAM);
            end else if (state == ST_STREAM) begin
              bin_data  <= (pix_data >= thr_q);
              bin_valid <= 1'b1;
              n_out     <= n;
              n         <= n + 1'b1;
              if (n == CNT_W'(FRAME_LAST)) begin
                state     <= ST_FLUSH;
                pix_ready <= 1'b0;
              end
            end
          end
        end

        ST_FLUSH: begin
          bin_data  <= 1'b0;
          bin_valid <= 1'b1;
          n_out     <= n;
          n         <= n + 1'b1;
          if (n == CNT_W'(BEAT_LAST)) begin
            state     <= ST_IDLE;
            pix_ready <= 1'b1;
            n         <= '0;
          end
        end

        default: begin
          state     <= ST_IDLE;
          pix_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_binarize_feeder.sv
// tb/tb_binarize_feeder.sv - randomized self-checking bench for binarize_feeder
module tb_binarize_feeder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pix_data = '0;
  logic       pix_valid = 1'b0;
  logic       pix_sof = 1'b0;
  logic       pix_ready;
  logic [7:0] thr = 8'd128;
  logic       bin_data, bin_valid, cal_valid, frame_done, frame_err;

  binarize_feeder #(.IMG_W(64), .IMG_H(64), .PIX_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_ready(pix_ready),
    .thr(thr),
    .bin_data(bin_data), .bin_valid(bin_valid), .cal_valid(cal_valid),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  logic bin_q[$];
  int   bin_cyc[$], cal_cyc[$], done_cyc[$], acc_cyc[$];
  int   err_cnt, rdy_low;

  logic [7:0] stim_pix[$], stim_thr[$];
  bit         stim_sof[$];
  logic       exp_bin[$];
  int         exp_idx[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) if (mon_en) begin
    if (bin_valid) begin bin_q.push_back(bin_data); bin_cyc.push_back(cyc); end
    if (cal_valid) cal_cyc.push_back(cyc);
    if (frame_done) done_cyc.push_back(cyc);
    if (frame_err) err_cnt++;
    if (!pix_ready) rdy_low++;
    if (pix_valid && pix_ready) acc_cyc.push_back(cyc);
  end

  // Reference rules: beats are numbered 0..4160 per frame, windows start at
  // beat 130 and recur on even columns of even rows of the shifted index.
  function automatic bit is_win(int i);
    return (i >= 130) && (((i - 130) % 2) == 0) && ((((i - 130) / 64) % 2) == 0);
  endfunction

  function automatic int exp_cal_count();
    int c = 0;
    foreach (exp_idx[j]) if (is_win(exp_idx[j])) c++;
    return c;
  endfunction

  function automatic int bin_mismatch();
    int bad = (bin_q.size() == exp_bin.size()) ? 0 : 1;
    for (int k = 0; k < exp_bin.size() && k < bin_q.size(); k++)
      if (bin_q[k] !== exp_bin[k]) bad++;
    return bad;
  endfunction

  function automatic int cal_misalign();
    int exp_c[$];
    int bad = 0;
    foreach (exp_idx[j]) if (is_win(exp_idx[j])) begin
      if (j < bin_cyc.size()) exp_c.push_back(bin_cyc[j] + 1); else bad++;
    end
    if (exp_c.size() != cal_cyc.size()) bad++;
    for (int k = 0; k < exp_c.size() && k < cal_cyc.size(); k++)
      if (exp_c[k] != cal_cyc[k]) bad++;
    return bad;
  endfunction

  task automatic clear_mon();
    bin_q.delete(); bin_cyc.delete(); cal_cyc.delete(); done_cyc.delete(); acc_cyc.delete();
    exp_bin.delete(); exp_idx.delete();
    err_cnt = 0; rdy_low = 0; mon_en = 1'b1;
  endtask

  // Queues one frame of stimulus and its expected output beats.
  task automatic add_frame(input int npix, input bit pattern, input int thr_m,
                           input int thr_sw, input int thr_new, input bit complete);
    for (int i = 0; i < npix; i++) begin
      logic [7:0] p;
      p = pattern ? 8'((i * 37) & 255) : 8'($urandom_range(0, 255));
      stim_pix.push_back(p);
      stim_sof.push_back(i == 0);
      stim_thr.push_back(i < thr_sw ? 8'(thr_m) : 8'(thr_new));
      exp_bin.push_back(int'(p) >= thr_m);
      exp_idx.push_back(i);
    end
    if (complete) for (int i = 4096; i < 4161; i++) begin
      exp_bin.push_back(1'b0); exp_idx.push_back(i);
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input bit sof, input logic [7:0] t, output bit ok);
    int waited = 0;
    pix_data = d; pix_sof = sof; thr = t; pix_valid = 1'b1; ok = 1'b0;
    while (!ok && waited < 200) begin
      @(negedge clk);
      if (pix_ready) ok = 1'b1;
      @(posedge clk); #1;
      waited++;
    end
    pix_valid = 1'b0; pix_sof = 1'b0;
  endtask

  task automatic run_stim(input bit gaps);
    bit ok;
    for (int k = 0; k < stim_pix.size(); k++) begin
      if (gaps) while ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
      send_beat(stim_pix[k], stim_sof[k], stim_thr[k], ok);
      if (!ok) begin
        checks++; failures++;
        $display("FAIL handshake_timeout beat=%0d ready stayed low, required high", k);
        break;
      end
    end
    stim_pix.delete(); stim_sof.delete(); stim_thr.delete();
  endtask

  task automatic settle();
    repeat (100) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({pix_ready, bin_data, bin_valid, cal_valid, frame_done, frame_err} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b required=000000",
               {pix_ready, bin_data, bin_valid, cal_valid, frame_done, frame_err});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_mon();
    for (int i = 0; i < 10; i++) begin
      pix_data = 8'($urandom_range(0, 255)); pix_valid = 1'b1; pix_sof = 1'b0;
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks++;
    if (rdy_low != 1) begin
      failures++; $display("FAIL ready_after_reset low_cycles=%0d required=1", rdy_low);
    end
    checks++;
    if (bin_cyc.size() + cal_cyc.size() + done_cyc.size() + err_cnt != 0) begin
      failures++;
      $display("FAIL idle_no_sof bin=%0d cal=%0d done=%0d err=%0d required all 0",
               bin_cyc.size(), cal_cyc.size(), done_cyc.size(), err_cnt);
    end
  endtask

  task automatic test_full_frame(input bit gaps);
    int bad;
    clear_mon();
    add_frame(4096, 1'b1, 128, 4096, 128, 1'b1);
    run_stim(gaps);
    settle();
    checks++;
    if (bin_q.size() != 4161) begin
      failures++; $display("FAIL frame_beats gaps=%0d got=%0d required=4161", gaps, bin_q.size());
    end
    checks++;
    bad = bin_mismatch();
    if (bad != 0) begin failures++; $display("FAIL frame_bin_data gaps=%0d errors=%0d required=0", gaps, bad); end
    checks++;
    if (rdy_low != 65) begin
      failures++; $display("FAIL flush_ready_low gaps=%0d got=%0d required=65", gaps, rdy_low);
    end
    checks++;
    if (cal_cyc.size() != 1024) begin
      failures++; $display("FAIL cal_count gaps=%0d got=%0d required=1024", gaps, cal_cyc.size());
    end
    checks++;
    bad = cal_misalign();
    if (bad != 0) begin failures++; $display("FAIL cal_alignment gaps=%0d errors=%0d required=0", gaps, bad); end
    checks++;
    if (done_cyc.size() != 1 || cal_cyc.size() == 0 || done_cyc[0] != cal_cyc[cal_cyc.size()-1]) begin
      failures++;
      $display("FAIL frame_done gaps=%0d pulses=%0d at=%0d required 1 pulse at last cal=%0d", gaps,
               done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1,
               cal_cyc.size() ? cal_cyc[cal_cyc.size()-1] : -1);
    end
    checks++;
    bad = (acc_cyc.size() == 4096 && bin_cyc.size() >= 4096) ? 0 : 1;
    for (int i = 0; i < 4096 && i < acc_cyc.size() && i < bin_cyc.size(); i++)
      if (bin_cyc[i] != acc_cyc[i] + 1) bad++;
    if (bad != 0) begin failures++; $display("FAIL accept_to_bin_latency gaps=%0d errors=%0d required=0", gaps, bad); end
    checks++;
    if (err_cnt != 0) begin failures++; $display("FAIL frame_err_spurious gaps=%0d got=%0d required=0", gaps, err_cnt); end
    if (!gaps && acc_cyc.size() > 257 && bin_cyc.size() > 257 && cal_cyc.size() > 1) begin
      checks++;
      if (cal_cyc[0] != acc_cyc[130] + 2 || cal_cyc[1] != acc_cyc[132] + 2) begin
        failures++;
        $display("FAIL first_cal_pulses got=%0d,%0d required=%0d,%0d",
                 cal_cyc[0], cal_cyc[1], acc_cyc[130] + 2, acc_cyc[132] + 2);
      end
      checks++;
      bad = 0;
      foreach (cal_cyc[k]) if (cal_cyc[k] > bin_cyc[194] && cal_cyc[k] <= bin_cyc[257] + 1) bad++;
      if (bad != 0) begin failures++; $display("FAIL odd_row_quiet pulses=%0d required=0", bad); end
    end
  endtask

  task automatic test_resync();
    int bad, first_new, exp_cnt;
    int thr_a = $urandom_range(1, 255);
    int thr_b = $urandom_range(1, 255);
    clear_mon();
    add_frame(2000, 1'b0, thr_a, 2000, thr_a, 1'b0);
    add_frame(4096, 1'b0, thr_b, 4096, thr_b, 1'b1);
    exp_cnt = exp_cal_count();
    run_stim(1'b0);
    settle();
    checks++;
    if (err_cnt != 1) begin failures++; $display("FAIL resync_frame_err got=%0d required=1", err_cnt); end
    checks++;
    if (rdy_low != 65) begin failures++; $display("FAIL resync_no_flush ready_low=%0d required=65", rdy_low); end
    checks++;
    bad = bin_mismatch();
    if (bad != 0) begin failures++; $display("FAIL resync_bin_data errors=%0d required=0", bad); end
    checks++;
    if (cal_cyc.size() != exp_cnt) begin
      failures++; $display("FAIL resync_cal_count got=%0d required=%0d", cal_cyc.size(), exp_cnt);
    end
    checks++;
    bad = cal_misalign();
    if (bad != 0) begin failures++; $display("FAIL resync_cal_alignment errors=%0d required=0", bad); end
    checks++;
    first_new = -1;
    if (acc_cyc.size() > 2130)
      foreach (cal_cyc[k]) if (first_new < 0 && cal_cyc[k] > acc_cyc[2000]) first_new = cal_cyc[k];
    if (acc_cyc.size() <= 2130 || first_new != acc_cyc[2130] + 2) begin
      failures++;
      $display("FAIL resync_first_cal got=%0d required=%0d", first_new,
               acc_cyc.size() > 2130 ? acc_cyc[2130] + 2 : -1);
    end
    checks++;
    if (done_cyc.size() != 1) begin failures++; $display("FAIL resync_frame_done got=%0d required=1", done_cyc.size()); end
  endtask

  task automatic test_thr_hold();
    int bad;
    clear_mon();
    add_frame(4096, 1'b0, 128, 1000, 10, 1'b1);
    run_stim(1'b1);
    settle();
    checks++;
    bad = bin_mismatch();
    if (bad != 0) begin failures++; $display("FAIL thr_latched errors=%0d required=0", bad); end
    checks++;
    if (cal_cyc.size() != 1024 || done_cyc.size() != 1) begin
      failures++;
      $display("FAIL thr_frame_cal cal=%0d done=%0d required 1024 and 1", cal_cyc.size(), done_cyc.size());
    end
  endtask

  task automatic test_async_reset();
    int bad;
    clear_mon();
    add_frame(3000, 1'b0, 10, 3000, 10, 1'b0);
    run_stim(1'b0);
    @(negedge clk); #1;
    checks++;
    if (bin_valid !== 1'b1 || pix_ready !== 1'b1) begin
      failures++; $display("FAIL midframe_active bin_valid=%b ready=%b required 1 1", bin_valid, pix_ready);
    end
    checks++;
    bad = bin_mismatch();
    if (bad != 0) begin failures++; $display("FAIL new_thr_after_sof errors=%0d required=0", bad); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({pix_ready, bin_data, bin_valid, cal_valid, frame_done, frame_err} !== 6'b0) begin
      failures++;
      $display("FAIL async_reset got=%b required=000000",
               {pix_ready, bin_data, bin_valid, cal_valid, frame_done, frame_err});
    end
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    clear_mon();
    for (int i = 0; i < 20; i++) begin
      pix_data = 8'($urandom_range(0, 255)); pix_valid = 1'b1; pix_sof = 1'b0;
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks++;
    if (bin_cyc.size() != 0) begin
      failures++; $display("FAIL restart_needs_sof beats=%0d required=0", bin_cyc.size());
    end
  endtask

  initial begin
    test_reset();
    test_full_frame(1'b0);
    test_full_frame(1'b1);
    test_resync();
    test_thr_hold();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout time=%0t required finish before 2000000", $time);
    $fatal(1);
  end

endmodule

// File: doc/binarize_feeder.md
# binarize_feeder

Front-end stage of the binary downscale path. Accepts a 64×64 8-bit grayscale pixel stream with a valid/ready handshake and thresholds each pixel to 1 bit. Drives the serial 1-bit pixel, its per-beat valid, and the window-aligned calculate strobe consumed by the downstream 2×2 resize stage. Appends the flush beats that stage needs to emit its last output row.

## Interface
- IMG_W, 64: pixels per row; must equal the downstream line-buffer row length
- IMG_H, 64: rows per frame
- PIX_W, 8: grayscale pixel width
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- pix_data  in  PIX_W  grayscale pixel
- pix_valid  in  1  pixel present
- pix_sof  in  1  qualifies pix_data as pixel (0,0) of a frame
- pix_ready  out  1  registered; beat accepted when pix_valid & pix_ready
- thr  in  PIX_W  binarization threshold
- bin_data  out  1  thresholded pixel or flush zero (downstream Din)
- bin_valid  out  1  one beat per cycle high (downstream Din_Valid)
- cal_valid  out  1  window holds an even-aligned 2×2 block (downstream Cal_Valid)
- frame_done  out  1  one-cycle pulse, frame fully emitted
- frame_err  out  1  one-cycle pulse, frame truncated by early sof

## Operation
- States: IDLE, STREAM, FLUSH. Reset enters IDLE.
- IDLE: accepted beats without sof are discarded. A sof beat is emitted as beat 0 and moves the block to STREAM. thr is latched into thr_q on that beat.
- Binarization: bin_data = (pix >= threshold), unsigned. The sof beat compares against live thr; all later beats of the frame compare against thr_q.
- STREAM: each accepted beat is emitted and increments beat counter n (13 bits). After beat IMG_W*IMG_H−1 (4095), the block moves to FLUSH.
- FLUSH: emits IMG_W+1 = 65 beats with bin_data=0 and bin_valid=1, one beat per cycle, with no input accepted. It then moves to IDLE. Total beats per frame: 4161 (n = 0..4160).
- cal_valid rule:
  - Let m = n − (2*IMG_W+2) = n − 130.
  - cal_valid follows beat n iff n ≥ 130, m[0]=0 (even column), and m[6]=0 (even row).
  - This yields exactly 1024 pulses per complete frame. The last pulse follows beat 4160.
- sof accepted in STREAM: the beat becomes beat 0 of a new frame. n restarts, thr_q is reloaded, no flush occurs for the old frame, and frame_err pulses.
- frame_done pulses in the same cycle as the final cal_valid of a frame.

## Timing
- Reset values: pix_ready=0, bin_data=0, bin_valid=0, cal_valid=0, frame_done=0, frame_err=0; state IDLE, n=0.
- pix_ready is 1 from the first edge after reset release. It is 0 in the cycle after the acceptance of beat 4095, throughout FLUSH, and returns to 1 in the cycle after the last flush beat.
- Pixel accepted at the end of cycle C → bin_data/bin_valid valid in C+1 → matching cal_valid in C+2.
- Input gaps (pix_valid=0) produce bin_valid=0 cycles. cal_valid never fires without a preceding beat.
- cal_valid and a new bin_valid may be high in the same cycle. The downstream stage samples its window before updating, so this is legal.
- Reset asserted mid-frame: all outputs clear immediately and the partial frame is abandoned. The next frame requires sof.

## Structure
- Shared package resize_pkg holds:
  - IMG_W, IMG_H
  - WIN_OFS = 2*IMG_W+2
  - FLUSH_LEN = IMG_W+1
  - FRAME_BEATS = IMG_W*IMG_H
  - the state enum
- The downstream resize stage also imports resize_pkg.
- No sub-module. The design is a single FSM, beat counter, and comparator.

## Test plan
- Reset, then hold pix_valid=1 with no sof for 10 cycles → pix_ready=1, bin_valid stays 0, and all other outputs stay 0.
- sof plus 4096 pixels with thr=128 and pix=(n*37)&0xFF → 4161 bin_valid beats. bin_data matches (pix ≥ 128) for n < 4096 and is 0 for the 65 flush beats. pix_ready is low for exactly 65 cycles.
- Same frame → 1024 cal_valid pulses. The first pulse is 2 cycles after acceptance of beat 130, the second after beat 132, and none follow beats 194–257. frame_done coincides with the final pulse.
- Random pix_valid gaps (50% duty) → identical bin_data sequence and cal_valid count. Each cal_valid follows its beat by exactly 1 cycle.
- sof re-asserted at pixel 2000 of a frame → frame_err pulses once, no flush occurs, and the next cal_valid follows the new beat 130.
- thr changed from 128 to 10 mid-frame → binarization keeps using thr_q=128 until the next sof. rst_n pulsed low at beat 3000 → all outputs become 0 asynchronously.
